// File: rtl/multi_timer_bridge.sv
// ---------------------------------------------------------------------------
// multi_timer_bridge
//
// CPU-side load/store bridge that maps a 256-byte I/O page onto NUM_CH
// independent down-counting timer channels and drives the CP0 hardware
// interrupt inputs.
//
// Each channel occupies 16 bytes (four word registers):
//   +0x0 CTRL    [0] EN, [2:1] MODE, [3] IM
//   +0x4 PRESET  CNT_W bits, zero-extended on read
//   +0x8 COUNT   read-only
//   +0xC STATUS  [0] PEND, write 1 to clear
//
// MODE 00 one-shot, 01 auto-reload, 10 periodic pulse, 11 behaves as 00.
//
// Ports:
//   clk    in   1   system clock, all state on rising edge
//   reset  in   1   asynchronous active-low reset, clears all state
//   addr   in  30   word address [31:2]; [15:8] page, [7:4] channel, [3:2] reg
//   dataI  in  32   store data
//   dataO  out 32   load data, combinational from addr, no read side effects
//   we     in   1   store strobe, one cycle per store
//   HWInt  out  6   interrupt lines [7:2]; channel i drives HWInt[2+i]
// ---------------------------------------------------------------------------
module multi_timer_bridge #(
   parameter int         NUM_CH  = 2,
   parameter int         CNT_W   = 32,
   parameter logic [7:0] BASE_HI = 8'h7f
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] addr,
   input  logic [31:0] dataI,
   output logic [31:0] dataO,
   input  logic        we,
   output logic [7:2]  HWInt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

   localparam logic [1:0]       MODE_RELOAD = 2'b01;
   localparam logic [1:0]       MODE_PULSE  = 2'b10;
   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

   // Per-channel state
   state_e           state_q  [NUM_CH];
   state_e           state_d  [NUM_CH];
   logic             en_q     [NUM_CH];
   logic             en_d     [NUM_CH];
   logic [1:0]       mode_q   [NUM_CH];
   logic [1:0]       mode_d   [NUM_CH];
   logic             im_q     [NUM_CH];
   logic             im_d     [NUM_CH];
   logic [CNT_W-1:0] preset_q [NUM_CH];
   logic [CNT_W-1:0] preset_d [NUM_CH];
   logic [CNT_W-1:0] count_q  [NUM_CH];
   logic [CNT_W-1:0] count_d  [NUM_CH];
   logic             pend_q   [NUM_CH];
   logic             pend_d   [NUM_CH];
   logic [5:0]       hwint_q;
   logic [5:0]       hwint_d;

   // Decode and per-channel strobes
   logic             hit_s;
   logic [3:0]       ch_s;
   logic [1:0]       reg_s;
   logic             valid_s;
   logic             wr_ctrl_s   [NUM_CH];
   logic             wr_preset_s [NUM_CH];
   logic             wr_status_s [NUM_CH];
   logic [NUM_CH-1:0] fire_s;
   logic [31:0]      rd_val_s    [NUM_CH];
   logic             unused_s;

   // addr is a word address, so the byte-address fields land at their natural indices.
   assign hit_s    = (addr[15:8] == BASE_HI);
   assign ch_s     = addr[7:4];
   assign reg_s    = addr[3:2];
   assign valid_s  = hit_s && ({28'd0, ch_s} < 32'(NUM_CH));
   assign unused_s = ^addr[31:16];

   // Per-channel write strobes; COUNT (reg 2) has no strobe, so writes to it vanish.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         wr_ctrl_s[i]   = we && valid_s && (ch_s == 4'(i)) && (reg_s == 2'd0);
         wr_preset_s[i] = we && valid_s && (ch_s == 4'(i)) && (reg_s == 2'd1);
         wr_status_s[i] = we && valid_s && (ch_s == 4'(i)) && (reg_s == 2'd3);
      end
   end

   // Next-state logic for every channel's FSM and registers.
   always_comb begin
      state_d  = state_q;
      en_d     = en_q;
      mode_d   = mode_q;
      im_d     = im_q;
      preset_d = preset_q;
      count_d  = count_q;
      pend_d   = pend_q;
      fire_s   = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         // A PRESET store while enabled restarts the channel from any state and
         // pre-empts whatever the FSM would otherwise do on this edge.
         if (wr_preset_s[i] && en_q[i]) begin
            state_d[i] = ST_LOAD;
         end else begin
            case (state_q[i])
               ST_IDLE: begin
                  if (wr_ctrl_s[i] && dataI[0]) begin
                     state_d[i] = ST_LOAD;
                  end else begin
                     state_d[i] = ST_IDLE;
                  end
               end
               ST_LOAD: begin
                  count_d[i] = preset_q[i];
                  state_d[i] = ST_CNT;
               end
               ST_CNT: begin
                  if (!en_q[i]) begin
                     state_d[i] = ST_CNT;
                  end else if (count_q[i] != CNT_ZERO) begin
                     count_d[i] = count_q[i] - CNT_ONE;
                  end else begin
                     state_d[i] = ST_INT;
                     // Pulse mode signals through the INT state only, never PEND.
                     fire_s[i]  = (mode_q[i] != MODE_PULSE);
                  end
               end
               ST_INT: begin
                  if ((mode_q[i] == MODE_RELOAD) || (mode_q[i] == MODE_PULSE)) begin
                     state_d[i] = ST_LOAD;
                  end else begin
                     en_d[i]    = 1'b0;
                     state_d[i] = ST_IDLE;
                  end
               end
               default: begin
                  state_d[i] = ST_IDLE;
               end
            endcase
         end

         if (wr_preset_s[i]) begin
            preset_d[i] = dataI[CNT_W-1:0];
         end else begin
            preset_d[i] = preset_q[i];
         end

         // Applied after the FSM so a software CTRL store beats the one-shot EN clear.
         if (wr_ctrl_s[i]) begin
            en_d[i]   = dataI[0];
            mode_d[i] = dataI[2:1];
            im_d[i]   = dataI[3];
         end else begin
            mode_d[i] = mode_q[i];
            im_d[i]   = im_q[i];
         end

         // Hardware set has priority over a simultaneous write-1-to-clear.
         if (fire_s[i]) begin
            pend_d[i] = 1'b1;
         end else if (wr_status_s[i] && dataI[0]) begin
            pend_d[i] = 1'b0;
         end else begin
            pend_d[i] = pend_q[i];
         end
      end
   end

   // Interrupt lines computed from next-state values so the registered copy
   // equals the same function of the current flops; unused lines stay 0.
   always_comb begin
      hwint_d = 6'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (mode_d[i] == MODE_PULSE) begin
            hwint_d[i] = im_d[i] && (state_d[i] == ST_INT);
         end else begin
            hwint_d[i] = im_d[i] && pend_d[i];
         end
      end
   end

   // Per-channel read values.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         case (reg_s)
            2'd0:    rd_val_s[i] = {28'd0, im_q[i], mode_q[i], en_q[i]};
            2'd1:    rd_val_s[i] = 32'(preset_q[i]);
            2'd2:    rd_val_s[i] = 32'(count_q[i]);
            2'd3:    rd_val_s[i] = {31'd0, pend_q[i]};
            default: rd_val_s[i] = 32'd0;
         endcase
      end
   end

   // Load data mux; unselected or out-of-range channels contribute zero.
   always_comb begin
      dataO = 32'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         dataO = dataO | ((valid_s && (ch_s == 4'(i))) ? rd_val_s[i] : 32'd0);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]  <= ST_IDLE;
            en_q[i]     <= 1'b0;
            mode_q[i]   <= 2'b00;
            im_q[i]     <= 1'b0;
            preset_q[i] <= CNT_ZERO;
            count_q[i]  <= CNT_ZERO;
            pend_q[i]   <= 1'b0;
         end
         hwint_q <= 6'd0;
      end else begin
         state_q  <= state_d;
         en_q     <= en_d;
         mode_q   <= mode_d;
         im_q     <= im_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         pend_q   <= pend_d;
         hwint_q  <= hwint_d;
      end
   end

   assign HWInt = hwint_q;

endmodule

// File: doc/multi_timer_bridge.md
Name: multi_timer_bridge

Overview:
- Parametrised successor to the two-timer system bridge: CPU-side load/store port decoding a 256-byte I/O page into NUM_CH built-in timer channels.
- Adds per-channel mode select (one-shot, auto-reload, periodic pulse), a sticky pending flag with write-1-to-clear, and an interrupt mask.
- Sits between the CPU data-memory port and the CP0 hardware-interrupt inputs.

Parameters:
NUM_CH, 2, number of timer channels; legal 1..6; channel i drives HWInt[2+i]
CNT_W, 32, counter/preset width; legal 8..32
BASE_HI, 8'h7f, value of addr[15:8] that selects this block

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; clears all state
addr  input  30  word address [31:2]
dataI  input  32  store data
dataO  output  32  load data, combinational
we  input  1  store strobe, one cycle per store
HWInt  output  6  interrupt lines [7:2]

Behaviour:
- Decode: hit = (addr[15:8]==BASE_HI); ch = addr[7:4]; reg = addr[3:2]. Channel valid only if hit and ch<NUM_CH; otherwise writes ignored, dataO=0.
- Register map per channel (offset = reg*4):
  - 0 CTRL: [0] EN, [2:1] MODE, [3] IM (1=interrupt enabled); other bits read 0.
  - 1 PRESET: CNT_W bits, zero-extended on read.
  - 2 COUNT: read-only; writes ignored.
  - 3 STATUS: [0] PEND; write with dataI[0]=1 clears; other bits ignored.
- dataO is combinational from addr; no read side effects.
- MODE: 00 one-shot, 01 auto-reload, 10 periodic pulse, 11 treated as 00.
- Writes take effect at the edge where we=1.
- Per-channel FSM, states IDLE, LOAD, CNT, INT:
  - IDLE: CTRL write with EN=1 -> LOAD; PRESET write with EN already 1 -> LOAD.
  - LOAD (1 cycle): COUNT<=PRESET; -> CNT.
  - CNT: EN=0 holds COUNT and stays in CNT. EN=1 and COUNT>0: COUNT<=COUNT-1. EN=1 and COUNT==0: -> INT; PEND<=1 for MODE 00/01/11.
  - INT (1 cycle): MODE 00/11 -> EN<=0, IDLE. MODE 01/10 -> LOAD.
  - A PRESET write in LOAD/CNT/INT with EN=1 -> LOAD (restart); with EN=0 the value is stored only and state is unchanged.
- Timing:
  - Auto-reload/pulse period with PRESET=P is P+3 cycles.
  - First INT occurs P+2 edges after the edge that enters LOAD.
  - P=0 gives INT two edges after LOAD entry.
- Interrupt output:
  - HWInt[2+i] = (PEND_i & IM_i) for MODE != 10.
  - HWInt[2+i] = (state_i==INT & IM_i) for MODE 10; PEND is not set in MODE 10.
  - Bits for i>=NUM_CH are 0.
- Simultaneous events:
  - PEND set and W1C clear on the same edge: set wins.
  - Software CTRL write and INT-state EN clear on the same edge: software write wins.
  - Changing MODE mid-count takes effect at the next INT.
- Reset (reset=0, any time): CTRL, PRESET, COUNT, PEND=0, all FSMs IDLE, HWInt=0. dataO reads 0 for all registers. Counting in progress is abandoned.
- Arithmetic: COUNT never wraps; the decrement is suppressed at 0.

Test Plan:
- Reset, then read every register of ch0..NUM_CH-1 plus ch=NUM_CH -> all dataO=0, HWInt=6'b0.
- ch0: PRESET=5, CTRL=0x9 (EN, one-shot, IM) -> COUNT 5,4,..,0 on successive edges, HWInt[2]=1 seven edges after the CTRL write edge. CTRL.EN then reads 0. Writing STATUS=1 drops HWInt[2] next edge.
- ch1: PRESET=3, CTRL=0xB (auto-reload) -> PEND set every 6 cycles. With IM=0 (CTRL=0x3), HWInt[3] stays 0 while STATUS reads 1.
- ch0: MODE 10, PRESET=2, IM=1 -> HWInt[2] is a 1-cycle pulse every 5 cycles and STATUS stays 0. EN=0 written mid-count -> COUNT frozen, resumes on EN=1.
- W1C to STATUS on the same edge the channel enters INT -> PEND remains 1. Write to addr[15:8]=8'h7e or to COUNT -> no state change.
- Assert reset while ch0 is in CNT with COUNT=1 -> HWInt=0 immediately (asynchronous). After release no interrupt fires until re-programmed.
